// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int NUM_CH = 4;

    // 10-bit frame plus one idle bit-time between frames.
    function automatic int frame_cycles(input int clk_freq, input int uart_bps);
        return 11 * (clk_freq / uart_bps);
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr.sv
// Combinational next-grant logic: round-robin after the last grant, or fixed
// priority (lowest index) when UART_ARB_FIXED_PRIO_EN is defined.
module uart_arb_rr
    import uart_tx_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] i_valid,
    input  logic [1:0]        i_last,
    output logic [NUM_CH-1:0] o_grant
);

    always_comb begin
        logic       w_found;
        logic [1:0] w_idx;
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 2'd0;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = 2'(i);
            if (!w_found && i_valid[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
`else
        // k = NUM_CH wraps back to the last winner, so it is searched last.
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = i_last + 2'(k);
            if (!w_found && i_valid[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Four-requester byte arbiter feeding an external UART transmitter; one frame
// per grant. Define UART_ARB_FIXED_PRIO_EN for fixed-priority arbitration.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int UART_BPS = 'd9600,
    parameter int CLK_FREQ = 'd50_000_000
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_CH-1:0]   ch_valid,
    input  logic [8*NUM_CH-1:0] ch_data,
    output logic [NUM_CH-1:0]   ch_ready,
    output logic [7:0]          tx_data,
    output logic                tx_flag,
    output logic                busy,
    output logic [1:0]          grant_id
);

    localparam int FRAME_CYCLES = frame_cycles(CLK_FREQ, UART_BPS);
    localparam int TW           = $clog2(FRAME_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_CYCLES - 1);

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [7:0]      r_tx_data;
    logic            r_tx_flag;
    logic [1:0]      r_grant_id;

    logic [NUM_CH-1:0] w_grant;
    logic [1:0]        w_idx;
    logic [7:0]        w_byte;

    uart_arb_rr u_arb (
        .i_valid (ch_valid),
        .i_last  (r_grant_id),
        .o_grant (w_grant)
    );

    assign w_idx    = onehot_to_idx(w_grant);
    assign w_byte   = ch_data[{w_idx, 3'b000} +: 8];
    assign ch_ready = (r_state == IDLE) ? w_grant : '0;

    // Transmitter samples pi_data live per bit, so tx_data only moves on a handshake.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_tx_data  <= 8'h00;
            r_tx_flag  <= 1'b0;
            r_grant_id <= 2'd3;
        end else begin
            r_tx_flag <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|ch_ready) begin
                        r_tx_data  <= w_byte;
                        r_grant_id <= w_idx;
                        r_tx_flag  <= 1'b1;
                        r_state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_timer <= '0;
                    r_state <= HOLD;
                end
                HOLD: begin
                    r_timer <= r_timer + TW'(1);
                    if (r_timer == TIMER_LAST) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_flag  = r_tx_flag;
    assign grant_id = r_grant_id;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized scoreboard bench for uart_tx_arb; the reference model predicts
// grants from the arbitration rules and the frame spacing.
module tb_uart_tx_arb;

    localparam int BPS = 5_000_000;
    localparam int CF  = 50_000_000;
    localparam int FC  = 110;
    localparam int GAP = FC + 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [3:0]  ch_valid;
    logic [31:0] ch_data;
    logic [3:0]  ch_ready;
    logic [7:0]  tx_data;
    logic        tx_flag;
    logic        busy;
    logic [1:0]  grant_id;

    uart_tx_arb #(.UART_BPS(BPS), .CLK_FREQ(CF)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .ch_valid  (ch_valid),
        .ch_data   (ch_data),
        .ch_ready  (ch_ready),
        .tx_data   (tx_data),
        .tx_flag   (tx_flag),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    int         errors = 0;
    int         checks = 0;
    bit         run = 0;
    int         m_last;
    bit         m_hs_vld;
    int         m_hs;
    logic [7:0] m_cur_d, m_prev_d;
    int         m_cur_id, m_prev_id;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, want);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int last);
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_hs_vld = 0; m_hs = 0; m_last = 3;
        m_cur_d = 8'h00; m_prev_d = 8'h00; m_cur_id = 3; m_prev_id = 3;
        q.delete();
    endtask

    // Drive one cycle of inputs and let the model decide whether it is a handshake.
    task automatic step(input logic rst, input logic [3:0] v, input logic [31:0] d);
        int   w;
        exp_t e;
        @(posedge sys_clk);
        #1;
        sys_rst_n = rst; ch_valid = v; ch_data = d;
        if (!rst) model_reset();
        else if ((!m_hs_vld || cyc >= m_hs + GAP) && v != 4'h0) begin
            w = pick(v, m_last);
            e.id = w; e.data = d[8*w +: 8]; e.cyc = cyc;
            q.push_back(e);
            m_prev_d = m_cur_d; m_prev_id = m_cur_id;
            m_cur_d = e.data; m_cur_id = w; m_last = w;
            m_hs = cyc; m_hs_vld = 1;
        end
    endtask

    always @(negedge sys_clk) begin
        if (run) begin
            if (!sys_rst_n) begin
                chk("rst_busy", busy, 0);
                chk("rst_flag", tx_flag, 0);
                chk("rst_grant_id", grant_id, 3);
                chk("rst_tx_data", tx_data, 0);
            end else begin
                if (ch_ready != 4'h0) begin
                    if (q.size() == 0) chk("unexpected_ready", ch_ready, 0);
                    else begin
                        mon_e = q.pop_front();
                        chk("ready_onehot", ch_ready, 32'(1) << mon_e.id);
                        chk("hs_cycle", cyc, mon_e.cyc);
                    end
                end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                    chk("missing_ready", ch_ready, 32'(1) << q[0].id);
                    void'(q.pop_front());
                end
                chk("tx_flag", tx_flag, m_hs_vld && cyc == m_hs + 1);
                chk("busy", busy, m_hs_vld && cyc > m_hs && cyc < m_hs + GAP);
                chk("tx_data", tx_data, (m_hs_vld && cyc > m_hs) ? m_cur_d : m_prev_d);
                chk("grant_id", grant_id, (m_hs_vld && cyc > m_hs) ? m_cur_id : m_prev_id);
            end
        end
    end

    initial begin
        logic [3:0] v;
        sys_rst_n = 1'b1; ch_valid = 4'h0; ch_data = 32'h0;
        model_reset();
        #2 sys_rst_n = 1'b0;
        run = 1;
        repeat (3) step(0, 4'h0, 32'h0);

        // Single request from ch2, data scrambled every cycle while the frame runs.
        step(1, 4'b0100, 32'h00A5_0000);
        repeat (GAP + 4) step(1, 4'h0, $urandom);

        // All four valid continuously from reset: 0,1,2,3,0 spaced GAP apart.
        repeat (2) step(0, 4'h0, 32'h0);
        repeat (5 * GAP + 5) step(1, 4'hF, $urandom);

        // Reset while the frame timer sits at 50, then ch0 in the first released cycle.
        repeat (2) step(0, 4'h0, 32'h0);
        step(1, 4'b0001, 32'h0000_003C);
        repeat (51) step(1, 4'h0, $urandom);
        repeat (3) step(0, 4'h0, $urandom);
        step(1, 4'b0001, 32'h1122_3344);

        // ch1 requests only during HOLD and withdraws before IDLE.
        repeat (20) step(1, 4'h0, $urandom);
        repeat (50) step(1, 4'b0010, $urandom);
        repeat (GAP) step(1, 4'h0, $urandom);

        // Random traffic with bursts and idle gaps.
        repeat (3000) begin
            v = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            step(1, v, $urandom);
        end
        repeat (GAP + 2) step(1, 4'h0, $urandom);

        @(posedge sys_clk);
        #1;
        if (q.size() != 0) chk("queue_drained", q.size(), 0);
        run = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter UART_BPS, default 'd9600, meaning the line baud rate and matching the downstream transmitter.
REQ-002 The block SHALL have parameter CLK_FREQ, default 'd50_000_000, meaning the sys_clk frequency in Hz.
REQ-003 The block SHALL have port sys_clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port sys_rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port ch_valid, input, 4 bits, where bit i means requester i offers a byte.
REQ-006 The block SHALL have port ch_data, input, 32 bits, where byte i (bits 8i+7:8i) is requester i's byte.
REQ-007 The block SHALL have port ch_ready, output, 4 bits, a one-hot accept; a transfer occurs on ch_valid[i] & ch_ready[i].
REQ-008 The block SHALL have port tx_data, output, 8 bits, driving the transmitter pi_data input.
REQ-009 The block SHALL have port tx_flag, output, 1 bit, a one-cycle start pulse driving the transmitter pi_flag input.
REQ-010 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-011 The block SHALL have port grant_id, output, 2 bits, the index of the last accepted requester.

Function
REQ-012 The block SHALL derive BAUD_CNT_MAX = CLK_FREQ/UART_BPS and FRAME_CYCLES = 11*BAUD_CNT_MAX (10-bit frame plus one idle bit-time).
REQ-013 The FSM SHALL have states IDLE, LAUNCH and HOLD.
REQ-014 In IDLE with any ch_valid bit set, the FSM SHALL assert ch_ready combinationally for exactly one winner, latch its byte into tx_data, update grant_id, and go to LAUNCH.
REQ-015 ch_ready SHALL be 0 in LAUNCH and HOLD, and 0 in IDLE when ch_valid is 0.
REQ-016 In LAUNCH, tx_flag SHALL be 1 for exactly one cycle (the cycle after the handshake), the frame timer SHALL load 0, and the FSM SHALL go to HOLD.
REQ-017 In HOLD, the timer SHALL increment each cycle, and at FRAME_CYCLES-1 the FSM SHALL return to IDLE.
REQ-018 tx_data SHALL stay stable from the handshake through the end of HOLD, because the transmitter samples pi_data live per bit.
REQ-019 The minimum spacing from one handshake to the next SHALL be FRAME_CYCLES+2 cycles.
REQ-020 Round-robin arbitration SHALL search from grant_id+1 upward, modulo 4, and grant the first valid requester.
REQ-021 Changes to ch_valid or ch_data outside IDLE SHALL be ignored, and a requester dropping valid before it is granted SHALL be legal.
REQ-022 The timer width SHALL be $clog2(FRAME_CYCLES)+1 bits, and its comparisons SHALL be unsigned.

Reset
REQ-023 On sys_rst_n low, the block SHALL set state IDLE, tx_data 8'h00, tx_flag 0, timer 0 and grant_id 2'd3, so that ch0 is searched first; busy SHALL be 0.
REQ-024 Reset asserted mid-frame SHALL abort immediately, SHALL NOT produce a tx_flag pulse, and the block SHALL accept again in the first cycle after release.

Configuration
REQ-025 With macro UART_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins), while grant_id SHALL still update.
REQ-026 Without UART_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-020.

Structure
REQ-027 A shared package SHALL hold the FSM state enumeration, the channel count 4, and the FRAME_CYCLES formula as a constant function.
REQ-028 Arbitration SHALL be a sub-module uart_arb_rr, which is combinational next-grant logic (valid and last grant in, one-hot grant out); the arbiter's sequential state (FSM, timer, grant_id register) SHALL remain in uart_tx_arb.
REQ-029 The transmitter itself SHALL NOT be instantiated inside the block; it is connected at the top level.

Verification (UART_BPS=5_000_000, CLK_FREQ=50_000_000, BAUD_CNT_MAX=10, FRAME_CYCLES=110)
REQ-030 Single: ch_valid=4'b0100 with byte2=8'hA5 from IDLE -> ch_ready=4'b0100 that cycle, tx_flag one cycle later, tx_data=8'hA5 held for 111 cycles, and the attached transmitter emits 0,1,0,1,0,0,1,0,1,1.
REQ-031 Round-robin: all four valid continuously after reset -> grants in order 0,1,2,3,0, with handshakes exactly 112 cycles apart.
REQ-032 Fixed priority (macro defined): all four valid -> ch0 granted every frame, and ch3 is never granted.
REQ-033 Hold stability: ch_data changes every cycle during HOLD -> tx_data unchanged, and ch_ready stays 4'b0000.
REQ-034 Reset mid-HOLD: sys_rst_n low at timer=50 -> busy=0, tx_flag=0, grant_id=3; after release with ch_valid=4'b0001, ch0 is granted in the first cycle.
REQ-035 Withdrawn request: ch1 asserts valid during HOLD and drops it before IDLE -> no ch1 grant, and the arbiter stays in IDLE with busy=0.
